// File: rtl/arb_rr_wt.sv
// Registered weighted round-robin arbiter with per-owner burst lock; weights active with ARB_RR_WT_WEIGHT_EN.
// Latency: req -> gnt one HCLK edge; handover is back-to-back with no idle cycle.
// Backpressure: en=0 freezes all state; a locked owner holds the grant until lock drops.
module arb_rr_wt #(
  parameter  int N  = 4,
  parameter  int CW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N*CW-1:0] weight,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_vld,
  output logic            gnt_last
);

  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] id_q, id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cred_q;
  logic [IW-1:0] cand;
  logic [IW-1:0] win_id;
  logic          win_vld;
  logic          rel;

`ifdef ARB_RR_WT_WEIGHT_EN
  logic [CW-1:0] cred_d;
  logic [CW-1:0] w_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_wsplit
    assign w_arr[k] = weight[k*CW +: CW];
  end
`else
  // Without weighting every quantum is a single cycle, so credit is constant zero.
  logic unused_weight;
  assign unused_weight = ^weight;
  assign cred_q        = '0;
`endif

  // Rotating search starting just after the last owner; the last owner is checked last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Owner gives up the bus when it stops requesting or its quantum is spent and unlocked.
  assign rel = ~req[id_q] | ((cred_q == '0) & ~lock[id_q]);

  // Next-state: arbitrate when idle or released, otherwise burn one credit.
  always_comb begin
    gnt_d  = gnt_q;
    id_d   = id_q;
    ptr_d  = ptr_q;
`ifdef ARB_RR_WT_WEIGHT_EN
    cred_d = cred_q;
`endif
    if (en) begin
      if (!gnt_vld || rel) begin
        if (win_vld) begin
          gnt_d         = '0;
          gnt_d[win_id] = 1'b1;
          id_d          = win_id;
          ptr_d         = win_id;
`ifdef ARB_RR_WT_WEIGHT_EN
          cred_d        = w_arr[win_id];
`endif
        end else begin
          gnt_d = '0;
          id_d  = '0;
        end
      end else begin
`ifdef ARB_RR_WT_WEIGHT_EN
        if (cred_q != '0) begin
          cred_d = cred_q - 1'b1;
        end
`endif
      end
    end
  end

  // State registers with synchronous active-low reset; requester 0 wins first after reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      gnt_q  <= '0;
      id_q   <= '0;
      ptr_q  <= IW'(N - 1);
`ifdef ARB_RR_WT_WEIGHT_EN
      cred_q <= '0;
`endif
    end else begin
      gnt_q  <= gnt_d;
      id_q   <= id_d;
      ptr_q  <= ptr_d;
`ifdef ARB_RR_WT_WEIGHT_EN
      cred_q <= cred_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = id_q;
  assign gnt_vld  = |gnt_q;
  assign gnt_last = gnt_vld & (cred_q == '0) & ~lock[id_q];

endmodule

// File: doc/arb_rr_wt.md
# arb_rr_wt

Registered, weighted round-robin arbiter with per-requester grant lock. It succeeds the combinational round-robin arbiter and is intended for the AHB-Lite / WishBone interconnect, where one master must keep the bus for a burst. Grant state, rotation pointer and quantum credit are held in flops, so `gnt` is glitch-free and can directly drive bus multiplexers.

## Interface
Parameters:
- `N`, 4: number of requesters (≥2).
- `CW`, 4: width of each per-requester weight field.
- `IW`, `$clog2(N)`: width of `gnt_id`; derived, not overridable.

Ports:
- `HCLK` in 1: clock; the only clock.
- `HRESETn` in 1: reset, synchronous, active-low.
- `en` in 1: arbitration enable; when 0, all state is frozen.
- `req` in N: request per requester.
- `lock` in N: burst lock; honoured only for the current owner.
- `weight` in N*CW: weight of requester k in `weight[k*CW +: CW]`; quantum is weight+1 cycles.
- `gnt` out N: registered one-hot grant, or all-zero.
- `gnt_id` out IW: binary index of the owner; 0 when `gnt_vld`=0.
- `gnt_vld` out 1: equals `|gnt`.
- `gnt_last` out 1: owner's credit is 0 and `lock[owner]`=0; marks the final cycle of the quantum.

## Operation
- **State:** `gnt`, owner index, rotation pointer `ptr` (last owner), credit counter `cred` (CW bits).
- **Reset** (`HRESETn`=0 at an edge): `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `gnt_last`=0, `ptr`=N-1, `cred`=0. Requester 0 therefore has top priority after reset.
- **IDLE** (`gnt_vld`=0): at each edge with `en`=1 and `|req`, grant the first requester in the order `ptr+1, ptr+2, …, ptr+N` (mod N). Then set `ptr` to the winner and load `cred` with `weight[winner]`.
- **GRANT:** the owner is released when `~req[owner] | (cred==0 & ~lock[owner])`.
- **Not released:** the owner keeps `gnt`, and `cred` decrements if non-zero. At 0, `cred` saturates; with `lock` held, the owner stays granted indefinitely.
- **Released, other requests pending:** re-arbitrate in the same edge using the rotation above. The outgoing owner is searched last, so it regains the grant only if it is the sole requester. In that case `cred` is reloaded.
- **Released, no requests:** `gnt` goes to 0 and the arbiter returns to IDLE. `ptr` keeps the last owner.
- **Requests from non-owners** never pre-empt the owner.
- **`en`=0:** `gnt`, `ptr` and `cred` hold their values. Outputs stay stable, and `req`/`lock` changes are ignored.
- **`gnt` one-hot:** `gnt` is one-hot or zero in every cycle; the bench asserts this.

## Timing
- `req` → `gnt` latency is 1 edge. A request at edge t is granted at edge t+1 if the arbiter is idle.
- Handover is back-to-back: the new owner's `gnt` rises on the same edge the old owner's falls, with no idle cycle.
- With continuous `req` and no `lock`, the owner holds `gnt` for exactly `weight+1` cycles.
- `gnt_last` is combinational from the registered state plus `lock`. It is high in the last cycle before a forced rotation.
- If the owner drops `req`, `gnt` is removed at the next edge, regardless of `cred`.
- Reset overrides `en`. Reset mid-burst clears the grant at that edge, with no handover.

## Configuration
- Macro: `ARB_RR_WT_WEIGHT_EN`.
- **Defined:** weighted quanta operate as described above.
- **Undefined:** the `weight` port remains but is ignored, and `cred` is tied to 0. Each grant lasts 1 cycle unless extended by `lock`. The block then behaves as a registered plain round-robin with burst lock.

## Test plan
- **Reset rotation:** N=4, all weights 0, `req`=4'b1111, `en`=1 after reset → `gnt` = 0001, 0010, 0100, 1000, 0001 on successive cycles; `gnt_id` = 0, 1, 2, 3, 0.
- **Weighting:** `weight[0]`=2, `weight[1]`=0, `req`=4'b0011 → `gnt`=0001 for 3 cycles, then 0010 for 1 cycle, repeating. `gnt_last` is high in cycle 3 of requester 0 and every cycle of requester 1.
- **Lock:** `req`=4'b0011, requester 0 granted, `lock[0]`=1 for 6 cycles with weight 0 → `gnt`=0001 held for all 6 cycles with `gnt_last`=0. At the first cycle after `lock[0]` drops, `gnt_last`=1, and the next edge gives `gnt`=0010. `lock[1]` asserted while requester 0 owns has no effect.
- **Early drop and idle:** `weight[2]`=7, `req`=4'b0100, then `req[2]` drops after 2 granted cycles → next edge `gnt`=0, `gnt_vld`=0. A later `req`=4'b0001 is granted 1 edge after it rises; `ptr`=2 is honoured, so requester 3 would win over 0 if both request.
- **Freeze:** mid-quantum with `cred`=3, `en`=0 for 4 cycles while `req` changes → `gnt` and `gnt_id` are unchanged. After `en` returns to 1, the owner holds for the remaining 3+1 cycles.
- **Reset mid-burst:** owner 2 locked, `HRESETn`=0 for 1 edge → `gnt`=0 at that edge. After release with `req`=4'b1111, the first grant goes to requester 0.
